// File: rtl/qqspi_arbiter.sv
// Two-port round-robin arbiter in front of one qqspi memory controller.
// Latches the winning request and turns the controller's held ready into a one-cycle pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate and latch winner on the next edge
// ISSUE | mem_valid high, waiting for controller ready
// RESP  | owner's ready pulse is high this cycle
// DRAIN | mem_valid low, waiting for controller to release ready
module qqspi_arbiter #(
  parameter logic P0_PSRAM_SPIFLASH = 1'b1,
  parameter logic P0_QUAD_MODE      = 1'b1,
  parameter logic P1_PSRAM_SPIFLASH = 1'b1,
  parameter logic P1_QUAD_MODE      = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        p0_valid,
  input  logic [22:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,

  input  logic        p1_valid,
  input  logic [22:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,

  output logic        mem_valid,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_psram_spiflash,
  output logic        mem_quad_mode,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic        mem_valid_q, mem_valid_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        psram_q, psram_d;
  logic        quad_q, quad_d;
  logic        p0_ready_q, p0_ready_d;
  logic        p1_ready_q, p1_ready_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;

  logic        owner;
  logic        winner;

  // Owner index is recoverable from the one-hot grant while a transaction is live.
  assign owner  = grant_q[1];
  // On a tie the port that did not win last time goes first.
  assign winner = (p0_valid && p1_valid) ? ~last_owner_q : p1_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      psram_q      <= P0_PSRAM_SPIFLASH;
      quad_q       <= P0_QUAD_MODE;
      p0_ready_q   <= 1'b0;
      p1_ready_q   <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      psram_q      <= psram_d;
      quad_q       <= quad_d;
      p0_ready_q   <= p0_ready_d;
      p1_ready_q   <= p1_ready_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    psram_d      = psram_q;
    quad_d       = quad_q;
    p0_ready_d   = 1'b0;
    p1_ready_d   = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (p0_valid || p1_valid) begin
          grant_d      = winner ? 2'b10 : 2'b01;
          last_owner_d = winner;
          mem_valid_d  = 1'b1;
          mem_addr_d   = winner ? p1_addr  : p0_addr;
          mem_wdata_d  = winner ? p1_wdata : p0_wdata;
          mem_wstrb_d  = winner ? p1_wstrb : p0_wstrb;
          psram_d      = winner ? P1_PSRAM_SPIFLASH : P0_PSRAM_SPIFLASH;
          quad_d       = winner ? P1_QUAD_MODE      : P0_QUAD_MODE;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_ready) begin
          if (owner) begin
            p1_ready_d = 1'b1;
            p1_rdata_d = mem_rdata;
          end else begin
            p0_ready_d = 1'b1;
            p0_rdata_d = mem_rdata;
          end
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        // The controller holds ready until it sees valid low; wait for it to let go.
        if (!mem_ready) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_valid          = mem_valid_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign mem_wstrb          = mem_wstrb_q;
  assign mem_psram_spiflash = psram_q;
  assign mem_quad_mode      = quad_q;
  assign p0_ready           = p0_ready_q;
  assign p1_ready           = p1_ready_q;
  assign p0_rdata           = p0_rdata_q;
  assign p1_rdata           = p1_rdata_q;
  assign grant              = grant_q;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Bench for qqspi_arbiter: directed scenarios then random traffic, all checked against
// an edge-by-edge transaction model derived from the arbitration and handshake rules.
module tb_qqspi_arbiter;

  localparam logic P0_PS = 1'b1;
  localparam logic P0_QM = 1'b1;
  localparam logic P1_PS = 1'b0;
  localparam logic P1_QM = 1'b0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rq_v [2];
  logic [22:0] rq_a [2];
  logic [31:0] rq_d [2];
  logic [3:0]  rq_s [2];
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  logic        p0_ready, p1_ready, mem_valid, mem_psram_spiflash, mem_quad_mode;
  logic [31:0] p0_rdata, p1_rdata, mem_wdata;
  logic [22:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  qqspi_arbiter #(
    .P0_PSRAM_SPIFLASH(P0_PS), .P0_QUAD_MODE(P0_QM),
    .P1_PSRAM_SPIFLASH(P1_PS), .P1_QUAD_MODE(P1_QM)
  ) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(rq_v[0]), .p0_addr(rq_a[0]), .p0_wdata(rq_d[0]), .p0_wstrb(rq_s[0]),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(rq_v[1]), .p1_addr(rq_a[1]), .p1_wdata(rq_d[1]), .p1_wstrb(rq_s[1]),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready_i), .mem_rdata(mem_rdata_i),
    .mem_psram_spiflash(mem_psram_spiflash), .mem_quad_mode(mem_quad_mode),
    .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: one outstanding transaction at most.
  bit          m_active, m_drain, m_last;
  int          m_resp_edge;
  logic [1:0]  m_grant;
  logic [22:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ps, m_qm;
  logic        m_rdy [2];
  logic [31:0] m_rdata [2];
  int          m_owner;

  bit auto_ctl = 0;
  bit auto_req = 0;
  int ctl_wait = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Applies the arbiter's rules to the inputs present just before the coming edge.
  task automatic model_edge();
    int w;
    m_rdy[0] = 1'b0;
    m_rdy[1] = 1'b0;
    if (!resetn) begin
      m_active = 0; m_drain = 0; m_last = 1; m_grant = 2'b00;
      m_addr = '0; m_wdata = '0; m_wstrb = '0; m_ps = P0_PS; m_qm = P0_QM;
      m_rdata[0] = '0; m_rdata[1] = '0; m_owner = 0;
    end else if (m_active) begin
      if (mem_ready_i) begin
        m_rdy[m_owner]   = 1'b1;
        m_rdata[m_owner] = mem_rdata_i;
        m_active    = 0;
        m_drain     = 1;
        m_resp_edge = cyc + 1;
      end
    end else if (m_drain) begin
      // One cycle of ready pulse, then leave once the controller's ready is low.
      if ((cyc + 1) >= m_resp_edge + 2 && !mem_ready_i) begin
        m_drain = 0;
        m_grant = 2'b00;
      end
    end else if (rq_v[0] || rq_v[1]) begin
      if (rq_v[0] && rq_v[1]) w = m_last ? 0 : 1;
      else                    w = rq_v[1] ? 1 : 0;
      m_owner  = w;
      m_last   = (w == 1);
      m_grant  = (w == 1) ? 2'b10 : 2'b01;
      m_addr   = rq_a[w];
      m_wdata  = rq_d[w];
      m_wstrb  = rq_s[w];
      m_ps     = (w == 1) ? P1_PS : P0_PS;
      m_qm     = (w == 1) ? P1_QM : P0_QM;
      m_active = 1;
    end
  endtask

  task automatic compare_all();
    check_val("mem_valid", 32'(mem_valid), 32'(m_active));
    check_val("grant",     32'(grant),     32'(m_grant));
    check_val("mem_addr",  32'(mem_addr),  32'(m_addr));
    check_val("mem_wdata", mem_wdata,      m_wdata);
    check_val("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
    check_val("strap_ps",  32'(mem_psram_spiflash), 32'(m_ps));
    check_val("strap_qm",  32'(mem_quad_mode),      32'(m_qm));
    check_val("p0_ready",  32'(p0_ready),  32'(m_rdy[0]));
    check_val("p1_ready",  32'(p1_ready),  32'(m_rdy[1]));
    check_val("p0_rdata",  p0_rdata,       m_rdata[0]);
    check_val("p1_rdata",  p1_rdata,       m_rdata[1]);
  endtask

  task automatic new_req(input int i);
    rq_v[i] = 1'b1;
    rq_a[i] = 23'($urandom);
    rq_d[i] = $urandom;
    rq_s[i] = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom);
  endtask

  task automatic drive_ctl();
    if (!resetn) begin
      mem_ready_i = 1'b0;
      ctl_wait    = -1;
    end else if (mem_valid && !mem_ready_i) begin
      if (ctl_wait < 0) ctl_wait = $urandom_range(5, 0);
      if (ctl_wait == 0) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = $urandom;
        ctl_wait    = -1;
      end else begin
        ctl_wait--;
      end
    end else if (!mem_valid && mem_ready_i) begin
      if ($urandom_range(1, 0) == 0) mem_ready_i = 1'b0;
    end else if (!mem_valid && !mem_ready_i && $urandom_range(49, 0) == 0) begin
      // Stray ready while nothing is outstanding; the arbiter has to ignore it.
      mem_ready_i = 1'b1;
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic drive_req();
    logic rdy;
    for (int i = 0; i < 2; i++) begin
      rdy = (i == 0) ? p0_ready : p1_ready;
      if (rdy) begin
        if ($urandom_range(1, 0) == 0) new_req(i);
        else rq_v[i] = 1'b0;
      end else if (!rq_v[i]) begin
        if ($urandom_range(2, 0) == 0) new_req(i);
      end else if ($urandom_range(7, 0) == 0) begin
        rq_a[i] = 23'($urandom);
        rq_d[i] = $urandom;
        rq_s[i] = 4'($urandom);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (auto_ctl) drive_ctl();
    if (auto_req) drive_req();
  endtask

  int order[$];
  int done;

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq_v[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; rq_s[i] = '0;
    end
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Single read with a slow controller.
    rq_v[0] = 1'b1; rq_a[0] = 23'h000010; rq_s[0] = 4'b0000; rq_d[0] = 32'h1111_2222;
    tick();
    check_val("rd_addr", 32'(mem_addr), 32'h10);
    repeat (20) tick();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    check_val("rd_rdata", p0_rdata, 32'hDEADBEEF);
    rq_v[0] = 1'b0; mem_ready_i = 1'b0;
    repeat (3) tick();

    // Both ports pending from reset: strict alternation starting with port 0.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    new_req(0); new_req(1);
    auto_ctl = 1; done = 0;
    for (int n = 0; n < 400 && done < 4; n++) begin
      tick();
      if (p0_ready) begin order.push_back(0); done++; end
      if (p1_ready) begin order.push_back(1); done++; end
    end
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
    check_val("rr_count", 32'(done), 32'd4);
    for (int k = 0; k < 4; k++)
      check_val("rr_order", 32'((order.size() > k) ? order[k] : 99), 32'(k % 2));
    auto_ctl = 0; mem_ready_i = 1'b0; ctl_wait = -1;
    repeat (4) tick();

    // Requester changes its address after grant; the latched copy must not move.
    rq_v[0] = 1'b1; rq_a[0] = 23'h001234; rq_s[0] = 4'b1111;
    tick();
    repeat (2) tick();
    rq_a[0] = 23'h7FFFFF;
    tick();
    check_val("latch_addr", 32'(mem_addr), 32'h1234);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    tick();
    rq_v[0] = 1'b0; mem_ready_i = 1'b0;
    repeat (3) tick();

    // Port 1 write aborted by reset while issued, then retried to completion.
    rq_v[1] = 1'b1; rq_a[1] = 23'h000042; rq_d[1] = 32'h0000A5A5; rq_s[1] = 4'b0011;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_val("rst_valid", 32'(mem_valid), 32'd0);
    repeat (3) tick();
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    tick();
    rq_v[1] = 1'b0; mem_ready_i = 1'b0;
    repeat (3) tick();

    // Random traffic with occasional resets.
    auto_ctl = 1; auto_req = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199, 0) == 0) begin
        resetn = 1'b0;
        mem_ready_i = 1'b0;
        ctl_wait = -1;
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qqspi_arbiter.md
Name: qqspi_arbiter

Overview:
Two-port round-robin arbiter that shares one qqspi memory controller between two requesters (e.g. CPU data port and a video/DMA fetch port). Latches the winning request, drives the controller's valid/addr/wdata/wstrb and per-port mode straps, and converts the controller's level-held ready into a one-cycle ready pulse per port. Sits between the bus interconnect and qqspi.

Parameters:
P0_PSRAM_SPIFLASH, 1, value driven on mem_psram_spiflash while port 0 is granted (1=PSRAM, 0=SPI flash)
P0_QUAD_MODE, 1, value driven on mem_quad_mode while port 0 is granted
P1_PSRAM_SPIFLASH, 1, same for port 1
P1_QUAD_MODE, 1, same for port 1

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous reset, active-low
p0_valid  in  1  port 0 request; held stable with addr/wdata/wstrb until p0_ready
p0_addr  in  23  port 0 word address (8Mx32)
p0_wdata  in  32  port 0 write data
p0_wstrb  in  4  port 0 byte strobes; 0 = read
p0_ready  out  1  one-cycle completion pulse
p0_rdata  out  32  read data, valid while p0_ready=1
p1_valid, p1_addr, p1_wdata, p1_wstrb, p1_ready, p1_rdata  same widths/meaning for port 1
mem_valid  out  1  to controller valid
mem_addr  out  23  to controller addr
mem_wdata  out  32  to controller wdata
mem_wstrb  out  4  to controller wstrb
mem_ready  in  1  controller ready (stays high until mem_valid drops)
mem_rdata  in  32  controller rdata
mem_psram_spiflash  out  1  controller PSRAM_SPIFLASH strap
mem_quad_mode  out  1  controller QUAD_MODE strap
grant  out  2  one-hot current owner, 00 when idle (debug/observability)

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE, mem_valid=0, mem_addr/wdata/wstrb=0, p0_ready=p1_ready=0, p0_rdata=p1_rdata=0, grant=00, last_owner=1 (port 0 wins first tie), mem straps = port 0 parameters.
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE: if exactly one pX_valid=1 -> grant that port. If both -> grant port != last_owner. Registered on this edge: mem_addr/wdata/wstrb from winner, straps from winner's parameters, grant one-hot, last_owner=winner, mem_valid=1, -> ISSUE. Requests arriving while not IDLE wait (no queueing; requester holds valid).
- ISSUE: mem_* held constant. On mem_ready=1: register pX_rdata=mem_rdata for owner, pX_ready=1 for owner, mem_valid=0 -> RESP.
- RESP: owner's ready high exactly this one cycle; cleared on next edge; -> DRAIN.
- DRAIN: mem_valid=0; wait until mem_ready=0, then grant=00 -> IDLE. If mem_ready already 0 in DRAIN, leave next edge.
- Latency: request seen at edge N -> mem_valid=1 after N; mem_ready sampled 1 at edge M -> pX_ready=1 during cycle after M. Minimum idle gap between consecutive transactions: RESP + DRAIN + IDLE = 3 cycles.
- Non-owner ready stays 0 throughout; non-owner rdata unchanged.
- Requester keeping valid=1 after its ready pulse is treated as a new request; with other port also pending, round-robin grants the other port first.
- pX_rdata holds last value until next completion for that port (reads and writes both update it from mem_rdata).
- Straps change only on grant edge in IDLE, never while mem_valid=1.
- Changes on p*_addr/wdata/wstrb after grant do not affect mem_* (latched).
- Reset mid-operation: all state returns to reset values on the reset edge; no ready pulse issued for the aborted transaction; controller shares resetn.
- mem_ready=1 while in IDLE (illegal): ignored, no grant blocked other than via normal arbitration.

Test Plan:
- Single read: p0_valid=1, p0_addr=23'h000010, p0_wstrb=0; model mem_ready=1 after 20 cycles with mem_rdata=32'hDEADBEEF -> mem_addr=0x10, mem_wstrb=0, one-cycle p0_ready with p0_rdata=32'hDEADBEEF, mem_valid low in RESP, p1_ready never 1.
- Simultaneous requests after reset: p0 and p1 valid same cycle, held -> port 0 served first, then port 1; grant sequence 01,00,10; second request issued only after mem_ready observed low.
- Back-to-back fairness: both ports hold valid for 4 transactions -> order 0,1,0,1.
- Write with strap switching: P1_PSRAM_SPIFLASH=0, P1_QUAD_MODE=0; p1 write wstrb=4'b0011, wdata=32'h0000A5A5 -> mem_wstrb=0011, mem_wdata=0x0000A5A5, mem_psram_spiflash=0, mem_quad_mode=0 constant during transaction; p1_ready pulse.
- Latch check: change p0_addr to 0x7FFFFF two cycles after grant -> mem_addr remains original value until completion.
- Reset mid-ISSUE: resetn=0 for one cycle while mem_valid=1 -> next cycle mem_valid=0, grant=00, no pX_ready pulse; subsequent request completes normally.
